// File: rtl/sb_dsp_pkg.sv
// Sound Blaster DSP shared definitions: command opcodes written to port 22Ch and
// the command/DMA sequencer state encoding.
// No ports (package).
package sb_dsp_pkg;

  localparam logic [7:0] CMD_SET_TC    = 8'h40;
  localparam logic [7:0] CMD_DMA8      = 8'h14;
  localparam logic [7:0] CMD_HALT      = 8'hD0;
  localparam logic [7:0] CMD_CONT      = 8'hD4;
  localparam logic [7:0] CMD_BLKSZ     = 8'h48;
  localparam logic [7:0] CMD_AUTO8     = 8'h1C;
  localparam logic [7:0] CMD_EXIT_AUTO = 8'hDA;

  typedef enum logic [2:0] {
    StIdle,
    StArgTc,
    StArgLo,
    StArgHi,
    StWait,
    StReq,
    StPaused
  } dsp_state_e;

endpackage

// File: rtl/sb_rate_timer.sv
// Sample-rate pacing timer. A load pulse arms the down-counter with
// (256-tc)*CLKS_PER_US-1; expire pulses for one cycle when it reaches zero.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : (re)start the period using the current tc
//   tc         : DSP time constant
//   expire     : one-cycle pulse at the end of the period
module sb_rate_timer #(
  parameter int unsigned CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] tc,
  output logic       expire
);

  localparam int unsigned W = 8 + $clog2(CLKS_PER_US) + 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] load_val;
  logic         armed_q;

  always_comb begin
    load_val = (W'(9'd256 - {1'b0, tc}) * W'(CLKS_PER_US)) - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else if (load) begin
      cnt_q   <= load_val;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cnt_q == '0) begin
        armed_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - W'(1);
      end
    end
  end

  always_comb begin
    expire = armed_q && (cnt_q == '0);
  end

endmodule

// File: rtl/sb_dma_ctrl.sv
// Sound Blaster DSP command sequencer and 8-bit single-cycle DMA playback controller.
// Parses 22Ch command bytes, paces DRQ1 from the time constant, latches each DMA
// byte as the current PCM sample and pulses IRQ7 at block end.
// Optional auto-init DMA (48h/1Ch/DAh) is built when SB_AUTOINIT_EN is defined.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   cmd_stb, cmd_data  : host byte written to 22Ch
//   dack_stb, dma_data : DMA write strobe while DACK1 low, and its data
//   irq_ack            : host read of 22Eh
//   drq, irq           : ISA DRQ1 / IRQ7 (active high)
//   pcm_sample, pcm_stb: last fetched unsigned sample and its update strobe
//   busy               : DMA block active
module sb_dma_ctrl
  import sb_dsp_pkg::*;
#(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned IRQ_PULSE   = 9,
  parameter logic [7:0]  TC_RESET    = 8'hA6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_stb,
  input  logic [7:0] cmd_data,
  input  logic       dack_stb,
  input  logic [7:0] dma_data,
  input  logic       irq_ack,
  output logic       drq,
  output logic       irq,
  output logic [7:0] pcm_sample,
  output logic       pcm_stb,
  output logic       busy
);

  localparam int unsigned IW = (IRQ_PULSE > 1) ? $clog2(IRQ_PULSE) : 1;

  dsp_state_e  state_q, state_d;
  logic [7:0]  tc_q, tc_d;
  logic [7:0]  lo_q, lo_d;
  logic [16:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [7:0]  pcm_q, pcm_d;
  logic        pcm_stb_q, pcm_stb_d;
  logic        irq_q, irq_d;
  logic [IW-1:0] irq_cnt_q, irq_cnt_d;
  logic        irq_set, irq_clr;
  logic        timer_load, expire;
  logic        fetch, last_byte;
  logic [16:0] blk_len;
`ifdef SB_AUTOINIT_EN
  logic        auto_q, auto_d;
  logic [16:0] blk_q, blk_d;
  logic        blksz_q, blksz_d;  // ARG_LO/HI sequence came from 48h
  dsp_state_e  ret_q, ret_d;      // where 48h resumes once its arguments are in
`endif

  sb_rate_timer #(
    .CLKS_PER_US(CLKS_PER_US)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .tc    (tc_q),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tc_q      <= TC_RESET;
      lo_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      pcm_q     <= 8'h80;
      pcm_stb_q <= 1'b0;
      irq_q     <= 1'b0;
      irq_cnt_q <= '0;
`ifdef SB_AUTOINIT_EN
      auto_q    <= 1'b0;
      blk_q     <= '0;
      blksz_q   <= 1'b0;
      ret_q     <= StIdle;
`endif
    end else begin
      state_q   <= state_d;
      tc_q      <= tc_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      pcm_q     <= pcm_d;
      pcm_stb_q <= pcm_stb_d;
      irq_q     <= irq_d;
      irq_cnt_q <= irq_cnt_d;
`ifdef SB_AUTOINIT_EN
      auto_q    <= auto_d;
      blk_q     <= blk_d;
      blksz_q   <= blksz_d;
      ret_q     <= ret_d;
`endif
    end
  end

  always_comb begin
    fetch     = (state_q == StReq) && dack_stb;
    last_byte = fetch && (cnt_q == 17'd1);
    blk_len   = {1'b0, cmd_data, lo_q} + 17'd1;
  end

  always_comb begin
    state_d    = state_q;
    tc_d       = tc_q;
    lo_d       = lo_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    pcm_d      = pcm_q;
    pcm_stb_d  = 1'b0;
    timer_load = 1'b0;
    irq_set    = 1'b0;
    irq_clr    = irq_ack;
`ifdef SB_AUTOINIT_EN
    auto_d     = auto_q;
    blk_d      = blk_q;
    blksz_d    = blksz_q;
    ret_d      = ret_q;
`endif

    // The DMA handshake is resolved first so a same-cycle command sees the
    // already-counted byte.
    if (fetch) begin
      pcm_d      = dma_data;
      pcm_stb_d  = 1'b1;
      cnt_d      = cnt_q - 17'd1;
      state_d    = StWait;
      timer_load = 1'b1;
      if (last_byte) begin
        irq_set = 1'b1;
`ifdef SB_AUTOINIT_EN
        if (auto_q) begin
          cnt_d = blk_q;
        end else begin
          state_d    = StIdle;
          busy_d     = 1'b0;
          timer_load = 1'b0;
        end
`else
        state_d    = StIdle;
        busy_d     = 1'b0;
        timer_load = 1'b0;
`endif
      end
    end else if ((state_q == StWait) && expire) begin
      state_d = StReq;
    end

    if (cmd_stb) begin
      case (state_q)
        StArgTc: begin
          tc_d    = cmd_data;
          state_d = StIdle;
          busy_d  = 1'b0;
`ifdef SB_AUTOINIT_EN
          auto_d  = 1'b0;
`endif
        end
        StArgLo: begin
          lo_d    = cmd_data;
          state_d = StArgHi;
        end
        StArgHi: begin
`ifdef SB_AUTOINIT_EN
          if (blksz_q) begin
            blk_d      = blk_len;
            state_d    = ret_q;
            timer_load = (ret_q == StWait);
          end else begin
            cnt_d      = blk_len;
            state_d    = StWait;
            busy_d     = 1'b1;
            timer_load = 1'b1;
            auto_d     = 1'b0;
          end
`else
          cnt_d      = blk_len;
          state_d    = StWait;
          busy_d     = 1'b1;
          timer_load = 1'b1;
`endif
        end
        default: begin
          case (cmd_data)
            CMD_SET_TC: state_d = StArgTc;
            CMD_DMA8: begin
              state_d = StArgLo;
`ifdef SB_AUTOINIT_EN
              blksz_d = 1'b0;
`endif
            end
            CMD_HALT: begin
              irq_clr = 1'b1;
              // A final byte accepted this cycle completes the block instead.
              if (((state_q == StWait) || (state_q == StReq)) && !last_byte) begin
                state_d = StPaused;
              end
            end
            CMD_CONT: begin
              if (state_q == StPaused) begin
                state_d    = StWait;
                timer_load = 1'b1;
              end
            end
`ifdef SB_AUTOINIT_EN
            CMD_BLKSZ: begin
              ret_d   = state_d;
              state_d = StArgLo;
              blksz_d = 1'b1;
            end
            CMD_AUTO8: begin
              if (blk_q != '0) begin
                cnt_d      = blk_q;
                auto_d     = 1'b1;
                state_d    = StWait;
                busy_d     = 1'b1;
                timer_load = 1'b1;
              end
            end
            CMD_EXIT_AUTO: auto_d = 1'b0;
`endif
            default: ;
          endcase
        end
      endcase
    end
  end

  // IRQ pulse stretcher; a new block end restarts the pulse.
  always_comb begin
    irq_d     = irq_q;
    irq_cnt_d = irq_cnt_q;
    if (irq_q) begin
      if (irq_cnt_q == '0) begin
        irq_d = 1'b0;
      end else begin
        irq_cnt_d = irq_cnt_q - IW'(1);
      end
    end
    if (irq_clr) begin
      irq_d     = 1'b0;
      irq_cnt_d = '0;
    end
    if (irq_set) begin
      irq_d     = 1'b1;
      irq_cnt_d = IW'(IRQ_PULSE - 1);
    end
  end

  always_comb begin
    drq        = (state_q == StReq);
    irq        = irq_q;
    busy       = busy_q;
    pcm_sample = pcm_q;
    pcm_stb    = pcm_stb_q;
  end

endmodule

// File: tb/tb_sb_dma_ctrl.sv
module tb_sb_dma_ctrl;

  localparam int CLKS = 50;
  localparam int IRQ_PULSE = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_stb = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       dack_stb = 1'b0;
  logic [7:0] dma_data = '0;
  logic       irq_ack = 1'b0;
  logic       drq, irq, pcm_stb, busy;
  logic [7:0] pcm_sample;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: bytes left in the block, auto-init mode and block size.
  int rem = 0;
  bit auto_m = 1'b0;
  int blk_m = 0;
  logic [7:0] exp_pcm[$];
  logic       exp_irq[$];  // expected busy level at each irq rising edge
  logic       irq_prev = 1'b0;

  sb_dma_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_stb   (cmd_stb),
    .cmd_data  (cmd_data),
    .dack_stb  (dack_stb),
    .dma_data  (dma_data),
    .irq_ack   (irq_ack),
    .drq       (drq),
    .irq       (irq),
    .pcm_sample(pcm_sample),
    .pcm_stb   (pcm_stb),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Monitor: every pcm_stb and irq rising edge is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pcm_stb) begin
        if (exp_pcm.size() == 0) check("pcm_stb_unexpected", pcm_stb, 1'b0);
        else check("pcm_sample", pcm_sample, exp_pcm.pop_front());
      end
      if (irq && !irq_prev) begin
        if (exp_irq.size() == 0) check("irq_unexpected", irq, 1'b0);
        else check("irq_busy", busy, exp_irq.pop_front());
      end
    end
    irq_prev <= irq;
  end

  function automatic int per(input logic [7:0] tc);
    return (256 - int'(tc)) * CLKS;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    cmd_data = b;
    cmd_stb  = 1'b1;
    tick();
    cmd_stb  = 1'b0;
  endtask

  task automatic wait_drq(input int budget, output int n);
    n = 0;
    while (!drq && n < budget) begin
      tick();
      n++;
    end
    if (!drq) check("drq_timeout", drq, 1'b1);
  endtask

  task automatic fetch(input logic [7:0] d, input logic halt);
    dma_data = d;
    dack_stb = 1'b1;
    if (halt) begin
      cmd_data = 8'hD0;
      cmd_stb  = 1'b1;
    end
    exp_pcm.push_back(d);
    rem--;
    if (rem == 0) begin
      if (auto_m) rem = blk_m;
      exp_irq.push_back(auto_m);
    end
    tick();
    dack_stb = 1'b0;
    cmd_stb  = 1'b0;
  endtask

  task automatic count_drq(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      tick();
      if (drq) seen++;
    end
  endtask

  // One single-cycle block; base < 0 selects random data.
  task automatic run_block(input logic [7:0] tc, input int len, input int base);
    int n;
    logic [7:0] d;
    wr(8'h40); wr(tc); wr(8'h14);
    wr(8'((len - 1) & 255)); wr(8'((len - 1) >> 8));
    rem = len;
    for (int i = 0; i < len; i++) begin
      wait_drq(per(tc) + 20, n);
      check("drq_gap", n, per(tc));
      repeat ($urandom_range(0, 3)) tick();
      check("drq_hold", drq, 1'b1);
      d = (base >= 0) ? 8'(base + i) : 8'($urandom);
      fetch(d, 1'b0);
    end
    check("busy_end", busy, 1'b0);
    check("irq_end", irq, 1'b1);
    check("pcm_last", pcm_sample, d);
    n = 0;
    while (irq && n < 50) begin
      tick();
      n++;
    end
    check("irq_width", n, IRQ_PULSE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    n_chk++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    int n, seen;
    logic [7:0] tc, junk[$];
    junk = '{8'h99, 8'hE1, 8'h10, 8'hD4};
`ifndef SB_AUTOINIT_EN
    junk.push_back(8'h1C); junk.push_back(8'h48); junk.push_back(8'hDA);
`endif

    // Reset values
    repeat (3) tick();
    check("rst_drq", drq, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_pcm", pcm_sample, 8'h80);
    check("rst_pcm_stb", pcm_stb, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // DMA strobe while idle is ignored
    dma_data = 8'h55; dack_stb = 1'b1; tick(); dack_stb = 1'b0; tick();
    check("idle_dack_pcm", pcm_sample, 8'h80);

    // Four-byte block at 1 us per sample, data 10h..13h
    run_block(8'hFF, 4, 16);

    // Halt / continue
    tc = 8'($urandom_range(8'hC0, 8'hFF));
    wr(8'h40); wr(tc); wr(8'h14); wr(8'h00); wr(8'h00);
    rem = 1;
    wait_drq(per(tc) + 20, n);
    check("drq_gap", n, per(tc));
    wr(8'hD0);
    check("halt_drq", drq, 1'b0);
    check("halt_busy", busy, 1'b1);
    count_drq(10000, seen);
    check("halt_no_drq", seen, 0);
    wr(8'hD4);
    wait_drq(per(tc) + 20, n);
    check("cont_gap", n, per(tc));
    fetch(8'($urandom), 1'b0);
    tick();
    check("irq_before_ack", irq, 1'b1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    check("irq_ack_clear", irq, 1'b0);
    seen = 0;
    repeat (12) begin tick(); if (irq) seen++; end
    check("irq_ack_cancel", seen, 0);

    // Same-cycle DMA byte and halt: byte counted, then pause; on last byte, complete
    wr(8'h40); wr(8'hFF); wr(8'h14); wr(8'h01); wr(8'h00);
    rem = 2;
    wait_drq(per(8'hFF) + 20, n);
    fetch(8'($urandom), 1'b1);
    check("dack_halt_drq", drq, 1'b0);
    check("dack_halt_busy", busy, 1'b1);
    count_drq(200, seen);
    check("dack_halt_hold", seen, 0);
    wr(8'hD4);
    wait_drq(per(8'hFF) + 20, n);
    check("cont_gap2", n, per(8'hFF));
    fetch(8'($urandom), 1'b1);
    check("last_halt_busy", busy, 1'b0);
    check("last_halt_irq", irq, 1'b1);
    tick();
    wr(8'hD0);
    check("d0_clears_irq", irq, 1'b0);

    // FFFFh length loads 65536; then reset while drq is high
    wr(8'h40); wr(8'hFF); wr(8'h14); wr(8'hFF); wr(8'hFF);
    rem = 65536;
    check("len_ffff", dut.cnt_q, 32'h10000);
    wait_drq(per(8'hFF) + 20, n);
    fetch(8'hC3, 1'b0);
    check("len_ffff_dec", dut.cnt_q, 32'hFFFF);
    wait_drq(per(8'hFF) + 20, n);
    tick();
    rst_n = 1'b0;
    #2;
    check("async_rst_drq", drq, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_pcm", pcm_sample, 8'h80);
    rem = 0;
    tick(); rst_n = 1'b1; tick();

    // Reset while irq is high, then TC must be back to A6h
    wr(8'h40); wr(8'hFF); wr(8'h14); wr(8'h00); wr(8'h00);
    rem = 1;
    wait_drq(per(8'hFF) + 20, n);
    fetch(8'h3C, 1'b0);
    tick();
    check("pre_rst_irq", irq, 1'b1);
    rst_n = 1'b0;
    #2;
    check("async_rst_irq", irq, 1'b0);
    tick(); rst_n = 1'b1; tick();
    wr(8'h14); wr(8'h00); wr(8'h00);
    rem = 1;
    wait_drq(per(8'hA6) + 20, n);
    check("tc_reset_gap", n, 4500);
    fetch(8'($urandom), 1'b0);
    repeat (12) tick();

    // Randomized blocks with ignored commands in between
    for (int b = 0; b < 4; b++) begin
      wr(junk[$urandom_range(0, junk.size() - 1)]);
      count_drq(60, seen);
      check("junk_no_drq", seen, 0);
      run_block(8'($urandom_range(240, 255)), int'($urandom_range(1, 4)), -1);
    end

`ifdef SB_AUTOINIT_EN
    wr(8'h40); wr(8'hFF); wr(8'h48); wr(8'h01); wr(8'h00);
    check("blksz_no_busy", busy, 1'b0);
    auto_m = 1'b1; blk_m = 2; rem = 2;
    wr(8'h1C);
    for (int i = 0; i < 6; i++) begin
      wait_drq(per(8'hFF) + 20, n);
      check("auto_gap", n, per(8'hFF));
      if (i == 4) begin
        wr(8'hDA);
        auto_m = 1'b0;
      end
      fetch(8'($urandom), 1'b0);
      if (i < 5) check("auto_busy", busy, 1'b1);
    end
    check("auto_exit_busy", busy, 1'b0);
    count_drq(200, seen);
    check("auto_exit_no_drq", seen, 0);
`else
    wr(8'h1C);
    count_drq(300, seen);
    check("auto8_ignored", seen, 0);
    check("auto8_no_busy", busy, 1'b0);
`endif

    repeat (20) tick();
    check("pcm_queue_drained", exp_pcm.size(), 0);
    check("irq_queue_drained", exp_irq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
